imem_responder: RTL

- Instruction-memory responder that serves fetch requests from the ifetch unit.
- Accepts word-address read requests over a valid/ready channel and returns instruction words in request order over a valid/ready response channel, after a fixed pipelined read latency.
- Buffers responses so that response backpressure never drops data.
- Supports redirect flush and a preload write port used by test/boot.

---
 rtl/imem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for the ifetch unit.
// Accepts in-order word reads and returns them after a fixed pipelined latency.
// A response FIFO absorbs backpressure so that no returning read is ever dropped.
module imem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [ADDR_WIDTH-1:0]         resp_addr,
  output logic                          resp_err,
  input  logic                          flush,
  input  logic                          ld_en,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned MemAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Stage 0 holds the freshly read word; stage LATENCY-1 is visible in cycle LATENCY.
  entry_t               stg_q [LATENCY];
  logic [LATENCY-1:0]   stg_v_q;

  entry_t               fifo_q [FIFO_DEPTH];
  logic [PtrW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic   req_hs, resp_hs, req_err, ld_ok;
  logic   fifo_empty, tail_v, push, fifo_pop;
  entry_t tail, head;

  assign req_err = 32'(req_addr) >= MEM_DEPTH;
  assign ld_ok   = 32'(ld_addr) < MEM_DEPTH;

  // Ready only from registered count, so a pop never feeds back into ready in the same cycle.
  assign req_ready = !reset && !flush && (cnt_q < CntW'(FIFO_DEPTH));
  assign req_hs    = req_valid && req_ready;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign tail_v     = stg_v_q[LATENCY-1];
  assign tail       = stg_q[LATENCY-1];
  // With an empty FIFO the pipe tail is presented directly, giving exactly LATENCY cycles.
  assign head       = fifo_empty ? tail : fifo_q[rd_ptr_q[PtrW-1:0]];

  assign resp_valid = !fifo_empty || tail_v;
  assign resp_hs    = resp_valid && resp_ready;
  // The tail is buffered unless it is being consumed straight through the bypass.
  assign push       = tail_v && !(fifo_empty && resp_hs);
  assign fifo_pop   = resp_hs && !fifo_empty;

  assign resp_data   = resp_valid ? head.data : '0;
  assign resp_addr   = resp_valid ? head.addr : '0;
  assign resp_err    = resp_valid ? head.err  : 1'b0;
  assign outstanding = cnt_q;

  // Preload port; out-of-range addresses are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_addr[MemAw-1:0]] <= ld_data;
    end
  end

  // Read stage plus delay stages; the nonblocking read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      stg_q[0].addr <= req_addr;
      stg_q[0].err  <= req_err;
      stg_q[0].data <= req_err ? '0 : mem[req_addr[MemAw-1:0]];
    end
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stg_q[i] <= stg_q[i-1];
    end
  end

  // Pipe valid bits; reset and flush both discard everything in flight.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stg_v_q <= '0;
    end else begin
      stg_v_q[0] <= req_hs;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stg_v_q[i] <= stg_v_q[i-1];
      end
    end
  end

  // Response buffer storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[PtrW-1:0]] <= tail;
    end
  end

  // Next-state for pointers and the outstanding count.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (PtrW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PtrW+1)'(fifo_pop);
    cnt_d    = cnt_q + CntW'(req_hs) - CntW'(resp_hs);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
